// File: rtl/elevator_ctrl_n.sv
// SCAN elevator controller for an N-floor car with latched hall/cabin calls and programmable door dwell.
// Optional build macro ELEV_DOOR_HOLD_EN adds a door_hold input that keeps the door open while asserted.
module elevator_ctrl_n #(
    parameter int NUM_FLOORS  = 4,
    parameter int DOOR_CYCLES = 3,
    localparam int PW = $clog2(2*NUM_FLOORS-1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-2:0] button_up,
    input  logic [NUM_FLOORS-2:0] button_down,
    input  logic [NUM_FLOORS-1:0] button_in,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [PW-1:0]         position,
    output logic                  open,
    output logic [1:0]            direction,
    output logic [NUM_FLOORS-2:0] pend_up,
    output logic [NUM_FLOORS-2:0] pend_down,
    output logic [NUM_FLOORS-1:0] pend_in
);

    localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR
    } state_t;

    state_t                  state_reg, state_next;
    logic [PW-1:0]           position_reg, position_next;
    logic                    moving_up_reg, moving_up_next;
    logic                    last_up_reg, last_up_next;
    logic [CW-1:0]           dwell_reg, dwell_next;
    logic [NUM_FLOORS-2:0]   pend_up_reg, pend_up_next;
    logic [NUM_FLOORS-2:0]   pend_down_reg, pend_down_next;
    logic [NUM_FLOORS-1:0]   pend_in_reg, pend_in_next;

    // Calls re-indexed per floor so every decision is a mask operation.
    logic [NUM_FLOORS-1:0]   eff_in, eff_up_f, eff_down_f, call_at;
    logic [NUM_FLOORS-1:0]   floor_oh, above_mask, below_mask, serve_mask;
    logic [PW-1:0]           cur_floor;
    logic                    call_here, call_above, call_below;
    logic                    cabin_here, up_here, down_here;
    logic                    at_floor, stop_here, serve, hold;

    assign eff_in     = pend_in_reg | button_in;
    assign eff_up_f   = {1'b0, pend_up_reg | button_up};
    assign eff_down_f = {pend_down_reg | button_down, 1'b0};
    assign call_at    = eff_in | eff_up_f | eff_down_f;

    assign cur_floor  = position_reg >> 1;
    assign at_floor   = ~position_reg[0];

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign floor_oh[gi]   = (cur_floor == PW'(gi));
            assign above_mask[gi] = (cur_floor <  PW'(gi));
            assign below_mask[gi] = (cur_floor >  PW'(gi));
        end
    endgenerate

    assign call_here  = |(call_at & floor_oh);
    assign call_above = |(call_at & above_mask);
    assign call_below = |(call_at & below_mask);
    assign cabin_here = |(eff_in & floor_oh);
    assign up_here    = |(eff_up_f & floor_oh);
    assign down_here  = |(eff_down_f & floor_oh);

    // A hall call only halts the car when it points the same way the car travels.
    assign stop_here = moving_up_reg ? (cabin_here | up_here   | ~call_above)
                                     : (cabin_here | down_here | ~call_below);

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        position_next  = position_reg;
        moving_up_next = moving_up_reg;
        last_up_next   = last_up_reg;
        dwell_next     = dwell_reg;
        serve          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (call_here) begin
                    state_next = ST_DOOR;
                    dwell_next = DWELL_LOAD;
                    serve      = 1'b1;
                end else if (call_above && (last_up_reg || !call_below)) begin
                    state_next     = ST_MOVE;
                    moving_up_next = 1'b1;
                    position_next  = position_reg + PW'(1);
                end else if (call_below) begin
                    state_next     = ST_MOVE;
                    moving_up_next = 1'b0;
                    position_next  = position_reg - PW'(1);
                end
            end
            ST_MOVE: begin
                if (at_floor && stop_here) begin
                    last_up_next = moving_up_reg;
                    if (call_here) begin
                        state_next = ST_DOOR;
                        dwell_next = DWELL_LOAD;
                        serve      = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (moving_up_reg) begin
                    position_next = position_reg + PW'(1);
                end else begin
                    position_next = position_reg - PW'(1);
                end
            end
            ST_DOOR: begin
                // Anything at this floor is absorbed by the open door and restarts the dwell.
                serve = 1'b1;
                if (call_here || hold) begin
                    dwell_next = DWELL_LOAD;
                end else if (dwell_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    dwell_next = dwell_reg - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign serve_mask     = serve ? floor_oh : '0;
    assign pend_in_next   = (pend_in_reg   | button_in)   & ~serve_mask;
    assign pend_up_next   = (pend_up_reg   | button_up)   & ~serve_mask[NUM_FLOORS-2:0];
    assign pend_down_next = (pend_down_reg | button_down) & ~serve_mask[NUM_FLOORS-1:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            position_reg  <= '0;
            moving_up_reg <= 1'b1;
            last_up_reg   <= 1'b1;
            dwell_reg     <= '0;
            pend_up_reg   <= '0;
            pend_down_reg <= '0;
            pend_in_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            position_reg  <= position_next;
            moving_up_reg <= moving_up_next;
            last_up_reg   <= last_up_next;
            dwell_reg     <= dwell_next;
            pend_up_reg   <= pend_up_next;
            pend_down_reg <= pend_down_next;
            pend_in_reg   <= pend_in_next;
        end
    end

    assign position  = position_reg;
    assign open      = (state_reg == ST_DOOR);
    assign direction = (state_reg == ST_MOVE) ? (moving_up_reg ? 2'b01 : 2'b10) : 2'b00;
    assign pend_up   = pend_up_reg;
    assign pend_down = pend_down_reg;
    assign pend_in   = pend_in_reg;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: a per-floor behavioural model checked every cycle,
// plus literal expectations for the documented scenarios (door-hold scenario under ELEV_DOOR_HOLD_EN).
module tb_elevator_ctrl_n;

    localparam int NF = 4;
    localparam int DC = 3;
    localparam int PW = $clog2(2*NF-1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NF-2:0] button_up = '0;
    logic [NF-2:0] button_down = '0;
    logic [NF-1:0] button_in = '0;
`ifdef ELEV_DOOR_HOLD_EN
    logic          door_hold = 1'b0;
`endif
    logic [PW-1:0] position;
    logic          open;
    logic [1:0]    direction;
    logic [NF-2:0] pend_up, pend_down;
    logic [NF-1:0] pend_in;

    int n_checks = 0;
    int n_errors = 0;

    elevator_ctrl_n #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .button_up(button_up),
        .button_down(button_down),
        .button_in(button_in),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .position(position),
        .open(open),
        .direction(direction),
        .pend_up(pend_up),
        .pend_down(pend_down),
        .pend_in(pend_in)
    );

    always #5 clk = ~clk;

    // Model: car position in half-floors, heading (+1/-1/0), open edges remaining,
    // and call flags indexed by the floor they belong to.
    int m_pos = 0;
    int m_dir = 0;
    int m_last = 1;
    int m_door = 0;
    bit m_cab[NF];
    bit m_up[NF];
    bit m_dn[NF];

    task automatic model_edge();
        bit cab[NF], up[NF], dn[NF];
        bit here, above, below, stop, hold_now, serve;
        int f, pick;
        for (int g = 0; g < NF; g++) begin
            cab[g] = m_cab[g] | button_in[g];
            up[g]  = m_up[g];
            dn[g]  = m_dn[g];
        end
        for (int k = 0; k < NF-1; k++) begin
            up[k]   = up[k]   | button_up[k];
            dn[k+1] = dn[k+1] | button_down[k];
        end
        f = m_pos / 2;
        here = cab[f] | up[f] | dn[f];
        above = 0;
        below = 0;
        for (int g = 0; g < NF; g++) begin
            if (g > f && (cab[g] | up[g] | dn[g])) above = 1;
            if (g < f && (cab[g] | up[g] | dn[g])) below = 1;
        end
        hold_now = 0;
`ifdef ELEV_DOOR_HOLD_EN
        hold_now = door_hold;
`endif
        serve = 0;
        if (m_door > 0) begin
            serve = 1;
            if (here || hold_now) m_door = DC;
            else m_door = m_door - 1;
        end else if (m_dir == 0) begin
            if (here) begin
                m_door = DC;
                serve = 1;
            end else begin
                pick = 0;
                if (m_last > 0 && above) pick = 1;
                else if (m_last < 0 && below) pick = -1;
                else if (above) pick = 1;
                else if (below) pick = -1;
                m_dir = pick;
                m_pos = m_pos + pick;
            end
        end else if (m_pos % 2 == 1) begin
            m_pos = m_pos + m_dir;
        end else begin
            stop = (m_dir > 0) ? (cab[f] || up[f] || !above) : (cab[f] || dn[f] || !below);
            if (stop) begin
                m_last = m_dir;
                m_dir = 0;
                if (here) begin
                    m_door = DC;
                    serve = 1;
                end
            end else begin
                m_pos = m_pos + m_dir;
            end
        end
        if (serve) begin
            cab[f] = 0;
            up[f] = 0;
            dn[f] = 0;
        end
        for (int g = 0; g < NF; g++) begin
            m_cab[g] = cab[g];
            m_up[g]  = up[g];
            m_dn[g]  = dn[g];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_pos = 0; m_dir = 0; m_last = 1; m_door = 0;
                for (int g = 0; g < NF; g++) begin
                    m_cab[g] = 0; m_up[g] = 0; m_dn[g] = 0;
                end
            end else begin
                model_edge();
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_dir();
        return (m_dir > 0) ? 32'd1 : (m_dir < 0) ? 32'd2 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_pend(input int which);
        logic [31:0] r = '0;
        for (int g = 0; g < NF; g++) begin
            if (which == 0 && g < NF-1) r[g] = m_up[g];
            if (which == 1 && g > 0)    r[g-1] = m_dn[g];
            if (which == 2)             r[g] = m_cab[g];
        end
        return r;
    endfunction

    // Advance one clock and compare every output against the model.
    task automatic step();
        @(negedge clk);
        chk("model_position",  32'(position),  32'(m_pos));
        chk("model_open",      32'(open),      (m_door > 0) ? 32'd1 : 32'd0);
        chk("model_direction", 32'(direction), exp_dir());
        chk("model_pend_up",   32'(pend_up),   exp_pend(0));
        chk("model_pend_down", 32'(pend_down), exp_pend(1));
        chk("model_pend_in",   32'(pend_in),   exp_pend(2));
        $display("t=%0t pos=%0d open=%0b dir=%0d up=%b dn=%b in=%b", $time,
                 position, open, direction, pend_up, pend_down, pend_in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        button_up = '1; button_down = '1; button_in = '1;
        #1;
        chk("rst_async_pos",  32'(position),  0);
        chk("rst_async_open", 32'(open),      0);
        chk("rst_async_dir",  32'(direction), 0);
        chk("rst_async_pend", 32'({pend_up, pend_down, pend_in}), 0);
        step();
        step();
        chk("rst_held_pend", 32'({pend_up, pend_down, pend_in}), 0);
        chk("rst_held_pos",  32'(position), 0);
        reset_n = 1'b1;
        button_up = '0; button_down = '0; button_in = '0;
    endtask

    typedef struct {
        int            gap;
        logic [NF-2:0] up;
        logic [NF-2:0] dn;
        logic [NF-1:0] cab;
    } vec_t;

    vec_t vecs[6] = '{
        '{2, 3'b000, 3'b100, 4'b0000},
        '{0, 3'b001, 3'b000, 4'b0000},
        '{5, 3'b000, 3'b000, 4'b0010},
        '{1, 3'b010, 3'b000, 4'b0000},
        '{3, 3'b000, 3'b010, 4'b1000},
        '{9, 3'b100, 3'b001, 4'b0001}
    };

    initial begin
        do_reset();

        // Cabin call to floor 2 from floor 0
        step();
        chk("a_idle_pos", 32'(position), 0);
        button_in = 4'b0100; step(); button_in = '0;
        chk("a_e1_pos", 32'(position), 1);
        chk("a_e1_dir", 32'(direction), 1);
        chk("a_e1_pend", 32'(pend_in), 32'b0100);
        step(); chk("a_e2_pos", 32'(position), 2);
        step(); chk("a_e3_pos", 32'(position), 3);
        step(); chk("a_e4_pos", 32'(position), 4);
        chk("a_e4_dir", 32'(direction), 1);
        chk("a_e4_open", 32'(open), 0);
        step(); chk("a_e5_open", 32'(open), 1);
        chk("a_e5_dir", 32'(direction), 0);
        chk("a_e5_pend", 32'(pend_in), 0);
        step(); step(); chk("a_e7_open", 32'(open), 1);
        step(); chk("a_e8_open", 32'(open), 0);
        chk("a_e8_pos", 32'(position), 4);

        // Up-call at floor 1 while passing towards floor 3
        do_reset();
        button_in = 4'b1000; step(); button_in = '0;
        chk("b_e1_pos", 32'(position), 1);
        button_up = 3'b010; step(); button_up = '0;
        chk("b_e2_pos", 32'(position), 2);
        chk("b_e2_pend", 32'(pend_up), 32'b010);
        step(); chk("b_e3_open", 32'(open), 1);
        chk("b_e3_pos", 32'(position), 2);
        chk("b_e3_pend", 32'(pend_up), 0);
        step(); step(); chk("b_e5_open", 32'(open), 1);
        step(); chk("b_e6_open", 32'(open), 0);
        step(); chk("b_e7_pos", 32'(position), 3);
        chk("b_e7_dir", 32'(direction), 1);
        repeat (3) step();
        chk("b_e10_pos", 32'(position), 6);
        step(); chk("b_e11_open", 32'(open), 1);
        repeat (3) step();
        chk("b_e14_open", 32'(open), 0);

        // Down-call at floor 1 is skipped on the way up, served after reversal
        do_reset();
        button_in = 4'b1000; step(); button_in = '0;
        button_down = 3'b001; step(); button_down = '0;
        chk("c_e2_pend", 32'(pend_down), 32'b001);
        step(); chk("c_e3_pos", 32'(position), 3);
        chk("c_e3_open", 32'(open), 0);
        repeat (3) step();
        chk("c_e6_pos", 32'(position), 6);
        step(); chk("c_e7_open", 32'(open), 1);
        repeat (3) step();
        chk("c_e10_open", 32'(open), 0);
        step(); chk("c_e11_pos", 32'(position), 5);
        chk("c_e11_dir", 32'(direction), 2);
        repeat (3) step();
        chk("c_e14_pos", 32'(position), 2);
        step(); chk("c_e15_open", 32'(open), 1);
        chk("c_e15_pend", 32'(pend_down), 0);
        repeat (3) step();
        chk("c_e18_open", 32'(open), 0);

        // Calls above and below at once: last direction (down) wins
        button_in = 4'b1001; step(); button_in = '0;
        chk("f_pos", 32'(position), 1);
        chk("f_dir", 32'(direction), 2);
        step();
        // Reset mid-move drops the pending floor-3 call
        do_reset();
        step(); step();
        chk("r_lost_pos", 32'(position), 0);
        chk("r_lost_dir", 32'(direction), 0);

        // Press at the current floor on the final open cycle
        button_in = 4'b0001; step(); button_in = '0;
        chk("d_e1_open", 32'(open), 1);
        chk("d_e1_pend", 32'(pend_in), 0);
        step(); step(); chk("d_e3_open", 32'(open), 1);
        button_up = 3'b001; step(); button_up = '0;
        chk("d_e4_open", 32'(open), 1);
        chk("d_e4_pend", 32'(pend_up), 0);
        step(); step(); chk("d_e6_open", 32'(open), 1);
        chk("d_e6_pend", 32'(pend_up), 0);
        step(); chk("d_e7_open", 32'(open), 0);

`ifdef ELEV_DOOR_HOLD_EN
        do_reset();
        button_in = 4'b0001; step(); button_in = '0;
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("h_held_open", 32'(open), 1);
        end
        door_hold = 1'b0;
        step(); step(); chk("h_rel2_open", 32'(open), 1);
        step(); chk("h_rel3_open", 32'(open), 0);
`endif

        // Mixed call table, checked against the model only
        do_reset();
        foreach (vecs[i]) begin
            repeat (vecs[i].gap) step();
            button_up = vecs[i].up; button_down = vecs[i].dn; button_in = vecs[i].cab;
            step();
            button_up = '0; button_down = '0; button_in = '0;
        end
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
